// File: rtl/fetch_decode_unit_if.sv
// Bus bundle for fetch_decode_unit: instruction-memory read channel plus the
// valid/ready issue channel toward the execute stage.
interface fetch_decode_unit_if #(
  parameter int PC_W = 8
);
  logic            mem_req;
  logic [PC_W-1:0] mem_addr;
  logic            mem_valid;
  logic [15:0]     mem_rdata;
  logic            issue_valid;
  logic            issue_ready;
  logic [2:0]      alu_sel;
  logic [7:0]      operand_b;

  modport master (
    output mem_req, mem_addr,
    input  mem_valid, mem_rdata,
    output issue_valid, alu_sel, operand_b,
    input  issue_ready
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_valid, mem_rdata,
    input  issue_valid, alu_sel, operand_b,
    output issue_ready
  );
endinterface

// File: rtl/fetch_decode_unit.sv
// Fetch/decode front end of the 8-bit CPU: owns the PC, resolves JMP/HALT/NOP locally
// and issues ALU ops downstream. Define FDU_JZ_EN to decode opcode 1011 as JZ.
module fetch_decode_unit #(
  parameter int PC_W     = 8,
  parameter int RESET_PC = 0
) (
  input  logic                clk,
  input  logic                rst,
  fetch_decode_unit_if.master bus,
  input  logic                zero_flag,
  output logic [PC_W-1:0]     pc_out,
  output logic                halted,
  output logic                illegal_op
);

  typedef enum logic [1:0] {
    FETCH,
    DECODE,
    ISSUE,
    HALT
  } state_t;

  localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'h9;
  localparam logic [3:0] OP_NOP  = 4'hA;
  localparam logic [3:0] OP_JZ   = 4'hB;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [11:0]     ir_q, ir_d;
  logic            mem_req_q, mem_req_d;
  logic            issue_valid_q, issue_valid_d;
  logic [2:0]      alu_sel_q, alu_sel_d;
  logic [7:0]      operand_b_q, operand_b_d;
  logic            halted_q, halted_d;
  logic            illegal_op_q, illegal_op_d;

  logic [3:0]      opcode;
  logic [7:0]      imm8;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] jump_target;
  logic            unused_bits;

  // The instruction register keeps only opcode and imm8; bits [11:8] are don't-care.
  assign opcode      = ir_q[11:8];
  assign imm8        = ir_q[7:0];
  assign pc_inc      = pc_q + PC_W'(1);
  assign jump_target = PC_W'(imm8);

`ifdef FDU_JZ_EN
  assign unused_bits = ^bus.mem_rdata[11:8];
`else
  assign unused_bits = ^{bus.mem_rdata[11:8], zero_flag};
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    mem_req_d     = mem_req_q;
    issue_valid_d = issue_valid_q;
    alu_sel_d     = alu_sel_q;
    operand_b_d   = operand_b_q;
    halted_d      = halted_q;
    illegal_op_d  = 1'b0;

    case (state_q)
      FETCH: begin
        // The request rises one cycle after entry, so mem_valid is only honoured once it is up.
        mem_req_d = 1'b1;
        if (mem_req_q && bus.mem_valid) begin
          ir_d      = {bus.mem_rdata[15:12], bus.mem_rdata[7:0]};
          mem_req_d = 1'b0;
          state_d   = DECODE;
        end
      end
      DECODE: begin
        state_d   = FETCH;
        mem_req_d = 1'b1;
        pc_d      = pc_inc;
        if (!opcode[3]) begin
          state_d       = ISSUE;
          mem_req_d     = 1'b0;
          issue_valid_d = 1'b1;
          alu_sel_d     = opcode[2:0];
          operand_b_d   = imm8;
        end else begin
          case (opcode)
            OP_JMP:  pc_d = jump_target;
            OP_HALT: begin
              state_d   = HALT;
              mem_req_d = 1'b0;
              pc_d      = pc_q;
              halted_d  = 1'b1;
            end
            OP_NOP:  pc_d = pc_inc;
`ifdef FDU_JZ_EN
            OP_JZ:   if (zero_flag) pc_d = jump_target;
`endif
            default: illegal_op_d = 1'b1;
          endcase
        end
      end
      ISSUE: begin
        if (bus.issue_ready) begin
          issue_valid_d = 1'b0;
          mem_req_d     = 1'b1;
          state_d       = FETCH;
        end
      end
      HALT: begin
        mem_req_d = 1'b0;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC_V;
      ir_q          <= '0;
      mem_req_q     <= 1'b0;
      issue_valid_q <= 1'b0;
      alu_sel_q     <= '0;
      operand_b_q   <= '0;
      halted_q      <= 1'b0;
      illegal_op_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      mem_req_q     <= mem_req_d;
      issue_valid_q <= issue_valid_d;
      alu_sel_q     <= alu_sel_d;
      operand_b_q   <= operand_b_d;
      halted_q      <= halted_d;
      illegal_op_q  <= illegal_op_d;
    end
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = pc_q;
  assign bus.issue_valid = issue_valid_q;
  assign bus.alu_sel     = alu_sel_q;
  assign bus.operand_b   = operand_b_q;
  assign pc_out          = pc_q;
  assign halted          = halted_q;
  assign illegal_op      = illegal_op_q;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Self-checking bench for fetch_decode_unit: an 8-bit-PC unit and a 4-bit-PC unit
// (RESET_PC=31, truncated to 15) run side by side against a program-walking scoreboard.
module tb_fetch_decode_unit;

  logic clk         = 1'b0;
  logic rst         = 1'b1;
  logic zero_flag   = 1'b0;
  logic issue_ready = 1'b0;
  logic mem_en      = 1'b1;
  bit   ready_random = 1'b0;
  bit   mem_random   = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] prog8 [256];
  logic [15:0] prog4 [16];

  logic [7:0]  exp_addr8 [$];
  logic [10:0] exp_iss8  [$];
  logic [3:0]  exp_addr4 [$];
  logic [10:0] exp_iss4  [$];
  int exp_ill8 = 0, exp_ill4 = 0, ill8 = 0, ill4 = 0;

  logic [7:0] pc_out8;
  logic       halted8, illegal8;
  logic [3:0] pc_out4;
  logic       halted4, illegal4;

  fetch_decode_unit_if #(.PC_W(8)) bus8 ();
  fetch_decode_unit_if #(.PC_W(4)) bus4 ();

  // Memory answers whenever mem_en is set, even with no request pending.
  assign bus8.mem_valid   = mem_en;
  assign bus8.mem_rdata   = prog8[bus8.mem_addr];
  assign bus8.issue_ready = issue_ready;
  assign bus4.mem_valid   = mem_en;
  assign bus4.mem_rdata   = prog4[bus4.mem_addr];
  assign bus4.issue_ready = issue_ready;

  fetch_decode_unit #(.PC_W(8), .RESET_PC(0)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8), .zero_flag(zero_flag),
    .pc_out(pc_out8), .halted(halted8), .illegal_op(illegal8)
  );

  fetch_decode_unit #(.PC_W(4), .RESET_PC(31)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .zero_flag(zero_flag),
    .pc_out(pc_out4), .halted(halted4), .illegal_op(illegal4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (ready_random) issue_ready = 1'($urandom_range(0, 1));
    if (mem_random)   mem_en      = 1'($urandom_range(0, 1));
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearProgs();
    foreach (prog8[i]) prog8[i] = 16'h9000;
    foreach (prog4[i]) prog4[i] = 16'h9000;
  endtask

  // Walk the program as an ISA interpreter, queueing every fetch address and issue.
  task automatic modelRun(input bit narrow);
    logic [7:0]  pc;
    logic [7:0]  mask;
    logic [15:0] w;
    bit          done;
    mask = narrow ? 8'h0F : 8'hFF;
    pc   = narrow ? 8'h0F : 8'h00;
    done = 1'b0;
    for (int s = 0; s < 64 && !done; s++) begin
      w = narrow ? prog4[pc[3:0]] : prog8[pc];
      if (narrow) exp_addr4.push_back(pc[3:0]);
      else        exp_addr8.push_back(pc);
      if (!w[15]) begin
        if (narrow) exp_iss4.push_back({w[14:12], w[7:0]});
        else        exp_iss8.push_back({w[14:12], w[7:0]});
        pc = pc + 8'd1;
      end else begin
        case (w[15:12])
          4'h8: pc = w[7:0];
          4'h9: done = 1'b1;
          4'hA: pc = pc + 8'd1;
`ifdef FDU_JZ_EN
          4'hB: pc = zero_flag ? w[7:0] : pc + 8'd1;
`endif
          default: begin
            if (narrow) exp_ill4++;
            else        exp_ill8++;
            pc = pc + 8'd1;
          end
        endcase
      end
      pc = pc & mask;
    end
  endtask

  task automatic applyStimulus(input bit check_reset);
    rst = 1'b1;
    tick();
    tick();
    if (check_reset) begin
      checkOutput("rst_mem_req", 32'(bus8.mem_req), 0);
      checkOutput("rst_mem_addr", 32'(bus8.mem_addr), 0);
      checkOutput("rst_issue_valid", 32'(bus8.issue_valid), 0);
      checkOutput("rst_alu_sel", 32'(bus8.alu_sel), 0);
      checkOutput("rst_operand_b", 32'(bus8.operand_b), 0);
      checkOutput("rst_halted", 32'(halted8), 0);
      checkOutput("rst_illegal", 32'(illegal8), 0);
      checkOutput("rst_pc_out", 32'(pc_out8), 0);
      checkOutput("rst_pc_out4_trunc", 32'(pc_out4), 15);
      checkOutput("rst_mem_addr4", 32'(bus4.mem_addr), 15);
    end
    exp_addr8.delete();
    exp_iss8.delete();
    exp_addr4.delete();
    exp_iss4.delete();
    exp_ill8 = 0;
    exp_ill4 = 0;
    ill8 = 0;
    ill4 = 0;
    modelRun(1'b0);
    modelRun(1'b1);
    rst = 1'b0;
  endtask

  task automatic finishTest(input string name);
    int cyc;
    cyc = 0;
    while (!(halted8 && halted4) && cyc < 1000) begin
      tick();
      cyc++;
    end
    checkOutput({name, "_halted"}, {30'd0, halted8, halted4}, 3);
    tick();
    tick();
    checkOutput({name, "_fetch8_left"}, 32'(exp_addr8.size()), 0);
    checkOutput({name, "_issue8_left"}, 32'(exp_iss8.size()), 0);
    checkOutput({name, "_fetch4_left"}, 32'(exp_addr4.size()), 0);
    checkOutput({name, "_issue4_left"}, 32'(exp_iss4.size()), 0);
    checkOutput({name, "_illegal8_cycles"}, 32'(ill8), 32'(exp_ill8));
    checkOutput({name, "_illegal4_cycles"}, 32'(ill4), 32'(exp_ill4));
  endtask

  logic        stall8_prev = 1'b0;
  logic [11:0] iss8_prev   = '0;
  always @(negedge clk) begin
    if (rst) begin
      stall8_prev = 1'b0;
    end else begin
      if (bus8.mem_req && bus8.mem_valid) begin
        if (exp_addr8.size() == 0) checkOutput("fetch8_unexpected", 32'(bus8.mem_addr), 32'hFFFF_FFFF);
        else checkOutput("fetch8_addr", 32'(bus8.mem_addr), 32'(exp_addr8.pop_front()));
      end
      if (bus8.issue_valid && issue_ready) begin
        if (exp_iss8.size() == 0) checkOutput("issue8_unexpected", {21'd0, bus8.alu_sel, bus8.operand_b}, 32'hFFFF_FFFF);
        else checkOutput("issue8", {21'd0, bus8.alu_sel, bus8.operand_b}, 32'(exp_iss8.pop_front()));
      end
      if (stall8_prev) checkOutput("hold8", {20'd0, bus8.issue_valid, bus8.alu_sel, bus8.operand_b}, {20'd0, iss8_prev});
      stall8_prev = bus8.issue_valid && !issue_ready;
      iss8_prev   = {bus8.issue_valid, bus8.alu_sel, bus8.operand_b};
      if (illegal8) ill8++;
    end
  end

  logic        stall4_prev = 1'b0;
  logic [11:0] iss4_prev   = '0;
  always @(negedge clk) begin
    if (rst) begin
      stall4_prev = 1'b0;
    end else begin
      if (bus4.mem_req && bus4.mem_valid) begin
        if (exp_addr4.size() == 0) checkOutput("fetch4_unexpected", 32'(bus4.mem_addr), 32'hFFFF_FFFF);
        else checkOutput("fetch4_addr", 32'(bus4.mem_addr), 32'(exp_addr4.pop_front()));
      end
      if (bus4.issue_valid && issue_ready) begin
        if (exp_iss4.size() == 0) checkOutput("issue4_unexpected", {21'd0, bus4.alu_sel, bus4.operand_b}, 32'hFFFF_FFFF);
        else checkOutput("issue4", {21'd0, bus4.alu_sel, bus4.operand_b}, 32'(exp_iss4.pop_front()));
      end
      if (stall4_prev) checkOutput("hold4", {20'd0, bus4.issue_valid, bus4.alu_sel, bus4.operand_b}, {20'd0, iss4_prev});
      stall4_prev = bus4.issue_valid && !issue_ready;
      iss4_prev   = {bus4.issue_valid, bus4.alu_sel, bus4.operand_b};
      if (illegal4) ill4++;
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          waited;
    logic [7:0]  exp_pc;
    logic [15:0] w;
    $display("[TB] starting fetch_decode_unit bench");

    // First ALU op after reset with zero-wait memory and an always-ready execute stage.
    clearProgs();
    prog8[0] = 16'h0205;
    issue_ready = 1'b1;
    mem_en = 1'b1;
    applyStimulus(1'b1);
    checkOutput("t1_req_low_on_release", 32'(bus8.mem_req), 0);
    tick();
    checkOutput("t1_req", 32'(bus8.mem_req), 1);
    checkOutput("t1_addr", 32'(bus8.mem_addr), 0);
    checkOutput("t1_no_issue_in_fetch", 32'(bus8.issue_valid), 0);
    tick();
    checkOutput("t1_no_issue_in_decode", 32'(bus8.issue_valid), 0);
    checkOutput("t1_no_req_in_decode", 32'(bus8.mem_req), 0);
    tick();
    checkOutput("t1_issue_valid", 32'(bus8.issue_valid), 1);
    checkOutput("t1_alu_sel", 32'(bus8.alu_sel), 0);
    checkOutput("t1_operand_b", 32'(bus8.operand_b), 32'h05);
    checkOutput("t1_pc", 32'(pc_out8), 1);
    finishTest("t1");

    // Stalled issue must hold its payload and keep the fetch side quiet.
    clearProgs();
    prog8[0] = 16'h3A7F;
    issue_ready = 1'b0;
    applyStimulus(1'b0);
    waited = 0;
    while (!bus8.issue_valid && waited < 20) begin
      tick();
      waited++;
    end
    checkOutput("t2_issue_seen", 32'(bus8.issue_valid), 1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("t2_hold_valid", 32'(bus8.issue_valid), 1);
      checkOutput("t2_hold_sel", 32'(bus8.alu_sel), 3);
      checkOutput("t2_hold_b", 32'(bus8.operand_b), 32'h7F);
      checkOutput("t2_hold_no_req", 32'(bus8.mem_req), 0);
      tick();
    end
    issue_ready = 1'b1;
    checkOutput("t2_no_req_on_accept", 32'(bus8.mem_req), 0);
    tick();
    checkOutput("t2_refetch_req", 32'(bus8.mem_req), 1);
    checkOutput("t2_refetch_addr", 32'(bus8.mem_addr), 1);
    checkOutput("t2_valid_dropped", 32'(bus8.issue_valid), 0);
    finishTest("t2");

    // Jumps on both widths, with random memory waits and random ready.
    clearProgs();
    prog8[0]    = 16'hA000;
    prog8[1]    = 16'hA000;
    prog8[2]    = 16'h8010;
    prog8[8'h10] = 16'h0111;
    prog4[15]   = 16'h8013;
    ready_random = 1'b1;
    mem_random   = 1'b1;
    applyStimulus(1'b0);
    finishTest("t3");
    checkOutput("t3_pc8_at_halt", 32'(pc_out8), 32'h11);
    checkOutput("t3_pc4_at_halt", 32'(pc_out4), 3);
    ready_random = 1'b0;
    mem_random   = 1'b0;
    tick();
    issue_ready = 1'b1;
    mem_en      = 1'b1;

    // PC wrap 15 -> 0 on the narrow unit, then HALT must stick.
    clearProgs();
    prog4[15] = 16'hA000;
    prog4[0]  = 16'h0A42;
    applyStimulus(1'b0);
    finishTest("t4");
    for (int i = 0; i < 6; i++) begin
      checkOutput("t4_halted8", 32'(halted8), 1);
      checkOutput("t4_halted4", 32'(halted4), 1);
      checkOutput("t4_req8_off", 32'(bus8.mem_req), 0);
      checkOutput("t4_req4_off", 32'(bus4.mem_req), 0);
      checkOutput("t4_issue4_off", 32'(bus4.issue_valid), 0);
      checkOutput("t4_pc4", 32'(pc_out4), 1);
      tick();
    end

    // Illegal opcode and JZ, taken and untaken.
    for (int z = 1; z >= 0; z--) begin
      clearProgs();
      prog8[0] = 16'hC000;
      prog8[1] = 16'hB020;
      zero_flag = z[0];
      applyStimulus(1'b0);
      waited = 0;
      while (!illegal8 && waited < 10) begin
        tick();
        waited++;
      end
      checkOutput("t5_illegal_seen", 32'(illegal8), 1);
      tick();
      checkOutput("t5_illegal_one_cycle", 32'(illegal8), 0);
      finishTest("t5");
`ifdef FDU_JZ_EN
      exp_pc = z[0] ? 8'h20 : 8'h02;
`else
      exp_pc = 8'h02;
`endif
      checkOutput("t5_pc_at_halt", 32'(pc_out8), 32'(exp_pc));
    end
    zero_flag = 1'b0;

    // Reset while stalled in ISSUE, with issue_ready arriving in the reset cycle.
    clearProgs();
    prog8[0] = 16'h3A7F;
    issue_ready = 1'b0;
    applyStimulus(1'b0);
    waited = 0;
    while (!bus8.issue_valid && waited < 20) begin
      tick();
      waited++;
    end
    checkOutput("t6_stall_seen", 32'(bus8.issue_valid), 1);
    tick();
    rst = 1'b1;
    issue_ready = 1'b1;
    tick();
    checkOutput("t6_issue_cleared", 32'(bus8.issue_valid), 0);
    checkOutput("t6_req_cleared", 32'(bus8.mem_req), 0);
    checkOutput("t6_pc_cleared", 32'(pc_out8), 0);
    checkOutput("t6_sel_cleared", 32'(bus8.alu_sel), 0);
    checkOutput("t6_b_cleared", 32'(bus8.operand_b), 0);

    // Reset while a fetch is waiting; mem_valid in the reset cycle is dropped.
    mem_en = 1'b0;
    applyStimulus(1'b0);
    tick();
    tick();
    tick();
    checkOutput("t6_req_waiting", 32'(bus8.mem_req), 1);
    checkOutput("t6_addr_waiting", 32'(bus8.mem_addr), 0);
    rst = 1'b1;
    mem_en = 1'b1;
    tick();
    checkOutput("t6_req_dropped", 32'(bus8.mem_req), 0);
    checkOutput("t6_no_issue", 32'(bus8.issue_valid), 0);
    tick();
    checkOutput("t6_no_decode_leak", 32'(bus8.issue_valid), 0);
    applyStimulus(1'b0);
    tick();
    checkOutput("t6_refetch_req", 32'(bus8.mem_req), 1);
    checkOutput("t6_refetch_addr", 32'(bus8.mem_addr), 0);
    finishTest("t6");

    // Random straight-line programs of ALU ops, NOPs and illegal words.
    clearProgs();
    for (int i = 0; i < 20; i++) begin
      w = 16'($urandom);
      case ($urandom_range(0, 3))
        0, 1:    w[15] = 1'b0;
        2:       w[15:12] = 4'hA;
        default: w[15:14] = 2'b11;
      endcase
      prog8[i] = w;
      if (i < 11) prog4[(i + 15) % 16] = w;
    end
    ready_random = 1'b1;
    mem_random   = 1'b1;
    applyStimulus(1'b0);
    finishTest("t7");
    ready_random = 1'b0;
    mem_random   = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
